// File: rtl/junction_phase_scheduler_pkg.sv
// Shared state encodings and lamp patterns for the junction phase scheduler.
package junction_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HW_GREEN  = 3'd0,
    HW_YELLOW = 3'd1,
    RED_A     = 3'd2,
    SR_GREEN  = 3'd3,
    SR_YELLOW = 3'd4,
    RED_B     = 3'd5
  } state_e;

  localparam logic [2:0] LED_GREEN  = 3'b100;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_RED    = 3'b001;

  function automatic logic [2:0] hw_lamp(input state_e s);
    logic [2:0] led;
    case (s)
      HW_GREEN:  led = LED_GREEN;
      HW_YELLOW: led = LED_YELLOW;
      default:   led = LED_RED;
    endcase
    return led;
  endfunction

  function automatic logic [2:0] sr_lamp(input state_e s);
    logic [2:0] led;
    case (s)
      SR_GREEN:  led = LED_GREEN;
      SR_YELLOW: led = LED_YELLOW;
      default:   led = LED_RED;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/junction_phase_scheduler_phase_timer.sv
// Loadable down-counter; expired flags a strobe arriving while the count sits at zero.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick_en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: load wins, otherwise count down on strobes and park at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick_en && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = tick_en & (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/junction_phase_scheduler.sv
// Two-road junction phase sequencer with registered lamp outputs and a phase-change pulse.
// Optional pedestrian request/walk ports are enabled by defining JUNCTION_PED_REQ_EN.
module junction_phase_scheduler
  import junction_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int HW_GREEN_MIN = 20,
  parameter int YELLOW_T     = 4,
  parameter int ALL_RED_T    = 2,
  parameter int SR_GREEN_T   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       sensor,
`ifdef JUNCTION_PED_REQ_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic [2:0] hw_led,
  output logic [2:0] sr_led,
  output logic [2:0] phase,
  output logic       time_out
);

  function automatic bit dur_ok(input int d);
    return (d >= 32'sd1) && (longint'(d) <= (64'sd1 << CNT_W));
  endfunction

  if ((CNT_W < 32'sd1) || (CNT_W > 32'sd30) ||
      !(dur_ok(HW_GREEN_MIN) && dur_ok(YELLOW_T) && dur_ok(ALL_RED_T) && dur_ok(SR_GREEN_T)))
  begin : g_param_err
    $fatal(1, "junction_phase_scheduler: phase duration outside 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] HWG_LOAD = CNT_W'(HW_GREEN_MIN - 32'sd1);
  localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(YELLOW_T - 32'sd1);
  localparam logic [CNT_W-1:0] RED_LOAD = CNT_W'(ALL_RED_T - 32'sd1);
  localparam logic [CNT_W-1:0] SRG_LOAD = CNT_W'(SR_GREEN_T - 32'sd1);

  function automatic logic [CNT_W-1:0] load_for(input state_e s);
    logic [CNT_W-1:0] v;
    case (s)
      HW_YELLOW, SR_YELLOW: v = YEL_LOAD;
      RED_A, RED_B:         v = RED_LOAD;
      SR_GREEN:             v = SRG_LOAD;
      default:              v = HWG_LOAD;
    endcase
    return v;
  endfunction

  state_e     state_q, state_d;
  logic       req_q, req_d;
  logic [2:0] hw_led_q, hw_led_d;
  logic [2:0] sr_led_q, sr_led_d;
  logic       time_out_q, time_out_d;
  logic       change_s;
  logic       expired_s;
  logic       any_req_s;
  logic       req_window_s;

`ifdef JUNCTION_PED_REQ_EN
  logic ped_walk_q, ped_walk_d;
  assign any_req_s  = sensor | ped_req;
  assign ped_walk_d = (state_d == SR_GREEN);
  assign ped_walk   = ped_walk_q;
`else
  assign any_req_s  = sensor;
`endif

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (HWG_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (change_s),
    .load_val (load_for(state_d)),
    .tick_en  (tick_en),
    .expired  (expired_s)
  );

  // next phase; illegal encodings fall back to highway green
  always_comb begin
    state_d = state_q;
    case (state_q)
      HW_GREEN: begin
        if (expired_s && (req_q || any_req_s)) state_d = HW_YELLOW;
        else                                   state_d = state_q;
      end
      HW_YELLOW: begin
        if (expired_s) state_d = RED_A;
        else           state_d = state_q;
      end
      RED_A: begin
        if (expired_s) state_d = SR_GREEN;
        else           state_d = state_q;
      end
      SR_GREEN: begin
        if (expired_s) state_d = SR_YELLOW;
        else           state_d = state_q;
      end
      SR_YELLOW: begin
        if (expired_s) state_d = RED_B;
        else           state_d = state_q;
      end
      RED_B: begin
        if (expired_s) state_d = HW_GREEN;
        else           state_d = state_q;
      end
      default: state_d = HW_GREEN;
    endcase
  end

  assign change_s     = (state_d != state_q);
  assign req_window_s = (state_q == HW_GREEN) || (state_q == HW_YELLOW) ||
                        (state_q == RED_A)    || (state_q == RED_B);

  // request latch: the side-road green it was waiting for consumes it
  always_comb begin
    req_d = req_q;
    if (change_s && (state_d == SR_GREEN)) begin
      req_d = 1'b0;
    end else if (any_req_s && req_window_s) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end
  end

  // output decode from the next state so lamps switch on the same edge as the phase
  always_comb begin
    hw_led_d   = hw_lamp(state_d);
    sr_led_d   = sr_lamp(state_d);
    time_out_d = change_s;
  end

  // state, request and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HW_GREEN;
      req_q      <= 1'b0;
      hw_led_q   <= LED_GREEN;
      sr_led_q   <= LED_RED;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      hw_led_q   <= hw_led_d;
      sr_led_q   <= sr_led_d;
      time_out_q <= time_out_d;
    end
  end

`ifdef JUNCTION_PED_REQ_EN
  // walk indication register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_walk_q <= 1'b0;
    end else begin
      ped_walk_q <= ped_walk_d;
    end
  end
`endif

  assign hw_led   = hw_led_q;
  assign sr_led   = sr_led_q;
  assign phase    = state_q;
  assign time_out = time_out_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a phase-level model.
module tb_junction_phase_scheduler;

  localparam int T_HWG = 3;
  localparam int T_Y   = 2;
  localparam int T_AR  = 1;
  localparam int T_SRG = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_en = 1'b0;
  logic       sensor = 1'b0;
  logic [2:0] hw_led, sr_led, phase;
  logic       time_out;
  bit         ped_v = 1'b0;
`ifdef JUNCTION_PED_REQ_EN
  logic       ped_req = 1'b0;
  logic       ped_walk;
`endif

  always #5 clk = ~clk;

  junction_phase_scheduler #(
    .CNT_W(8), .HW_GREEN_MIN(T_HWG), .YELLOW_T(T_Y), .ALL_RED_T(T_AR), .SR_GREEN_T(T_SRG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .sensor(sensor),
`ifdef JUNCTION_PED_REQ_EN
    .ped_req(ped_req), .ped_walk(ped_walk),
`endif
    .hw_led(hw_led), .sr_led(sr_led), .phase(phase), .time_out(time_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // model: phase index 0..5, strobes still needed before the phase may end
  int m_ph, m_left;
  bit m_req, m_to;

  // observations taken from the DUT for the hand-computed checks
  int obs_cyc, pulses, hwg_run, hwg_expect, walk_cycles;
  int enter[6];
  bit chk_hwg;

  function automatic int dur(input int p);
    case (p)
      0: return T_HWG;
      1: return T_Y;
      2: return T_AR;
      3: return T_SRG;
      4: return T_Y;
      default: return T_AR;
    endcase
  endfunction

  function automatic int hw_exp(input int p);
    return (p == 0) ? 4 : (p == 1) ? 2 : 1;
  endfunction

  function automatic int sr_exp(input int p);
    return (p == 3) ? 4 : (p == 4) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_left = T_HWG; m_req = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit sn, input bit pd);
    bit any, go;
    int nxt;
    any = sn | pd;
    go  = tk && (m_left == 1) && ((m_ph != 0) || m_req || any);
    if (tk && m_left > 1) m_left--;
    nxt = go ? (m_ph + 1) % 6 : m_ph;
    if (any && (m_ph == 0 || m_ph == 1 || m_ph == 2 || m_ph == 5)) m_req = 1'b1;
    if (go && nxt == 3) m_req = 1'b0;
    m_to = go;
    if (go) begin
      m_ph = nxt;
      m_left = dur(nxt);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, obs_cyc, $time);
    end
  endtask

  task automatic clear_obs();
    pulses = 0; hwg_run = 0; walk_cycles = 0;
    for (int i = 0; i < 6; i++) enter[i] = -1;
  endtask

  task automatic compare();
    check("phase", int'(phase), m_ph);
    check("hw_led", int'(hw_led), hw_exp(m_ph));
    check("sr_led", int'(sr_led), sr_exp(m_ph));
    check("time_out", int'(time_out), int'(m_to));
    check("heads_both_lit", int'((hw_led != 3'b001) && (sr_led != 3'b001)), 0);
`ifdef JUNCTION_PED_REQ_EN
    check("ped_walk", int'(ped_walk), int'(m_ph == 3));
    if (ped_walk) walk_cycles++;
`endif
    if (time_out) begin
      pulses++;
      if (phase < 3'd6 && enter[phase] < 0) enter[phase] = obs_cyc;
    end
    if (phase == 3'd0) hwg_run++;
    else begin
      if (hwg_run > 0 && chk_hwg) check("hw_green_len", hwg_run, hwg_expect);
      hwg_run = 0;
    end
  endtask

  task automatic step(input bit tk, input bit sn, input bit pd);
    tick_en = tk; sensor = sn; ped_v = pd;
`ifdef JUNCTION_PED_REQ_EN
    ped_req = pd;
`endif
    @(posedge clk);
    model_step(tk, sn, pd);
    @(negedge clk);
    obs_cyc++;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick_en = 1'b0; sensor = 1'b0; ped_v = 1'b0;
`ifdef JUNCTION_PED_REQ_EN
    ped_req = 1'b0;
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    obs_cyc = 0;
    compare();
    clear_obs();
    rst_n = 1'b1;
    compare();
  endtask

  initial begin
    bit seen;
    chk_hwg = 1'b0; hwg_expect = T_HWG;
    clear_obs();

    // 1: no traffic, highway green holds
    do_reset();
    for (int c = 0; c < 50; c++) step(1'b1, 1'b0, 1'b0);
    check("s1_pulses", pulses, 0);
    check("s1_phase", int'(phase), 0);

    // 2: single sensor pulse at cycle 1
    do_reset();
    for (int c = 0; c < 25; c++) step(1'b1, c == 1, 1'b0);
    check("s2_enter_hwy", enter[1], 3);
    check("s2_enter_reda", enter[2], 5);
    check("s2_enter_srg", enter[3], 6);
    check("s2_enter_sry", enter[4], 9);
    check("s2_enter_redb", enter[5], 11);
    check("s2_enter_hwg", enter[0], 12);
    check("s2_pulses", pulses, 6);

    // 3: sensor held, continuous cycling
    do_reset();
    chk_hwg = 1'b1; hwg_expect = 3;
    for (int c = 0; c < 40; c++) step(1'b1, 1'b1, 1'b0);
    check("s3_pulses", pulses, 19);
    chk_hwg = 1'b0;

    // 4: strobe every 4th cycle
    do_reset();
    chk_hwg = 1'b1; hwg_expect = 12;
    for (int c = 0; c < 60; c++) step((c % 4) == 3, c == 1, 1'b0);
    check("s4_enter_hwy", enter[1], 12);
    chk_hwg = 1'b0;

    // 5: asynchronous reset in the middle of side-road green
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step(1'b1, c == 1, 1'b0);
      if (phase == 3'd3) seen = 1'b1;
    end
    check("s5_reached_srg", int'(seen), 1);
    step(1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("s5_async_hw", int'(hw_led), 4);
    check("s5_async_sr", int'(sr_led), 1);
    check("s5_async_phase", int'(phase), 0);
    check("s5_async_to", int'(time_out), 0);
    @(posedge clk);
    @(negedge clk);
    compare();
    clear_obs();
    rst_n = 1'b1;
    obs_cyc = 0;
    compare();
    for (int c = 0; c < 30; c++) step(1'b1, 1'b0, 1'b0);
    check("s5_req_lost", pulses, 0);

`ifdef JUNCTION_PED_REQ_EN
    // 6: pedestrian request alone
    do_reset();
    for (int c = 0; c < 25; c++) step(1'b1, 1'b0, c == 1);
    check("s6_enter_hwy", enter[1], 3);
    check("s6_enter_srg", enter[3], 6);
    check("s6_enter_hwg", enter[0], 12);
    check("s6_pulses", pulses, 6);
    check("s6_walk_cycles", walk_cycles, 3);
`endif

    // random traffic and strobes
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit pd;
      pd = 1'b0;
`ifdef JUNCTION_PED_REQ_EN
      pd = ($urandom_range(0, 19) == 0);
`endif
      step($urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, pd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/junction_phase_scheduler.md
Name: junction_phase_scheduler

Overview:
- Master phase sequencer for a two-road junction: highway (HW) and side road (SR).
- Owns the phase timer and sequences both light heads through green, yellow and all-red clearance.
- Emits a one-cycle time_out pulse on every phase change, so the existing per-road light controllers can be slaved to it.
- Sits between the 1 Hz tick prescaler and the lamp drivers.

Parameters:
- CNT_W, 8: phase timer width.
- HW_GREEN_MIN, 20: minimum highway green, in ticks.
- YELLOW_T, 4: yellow duration for either road, in ticks.
- ALL_RED_T, 2: all-red clearance duration, in ticks.
- SR_GREEN_T, 10: side-road green duration, in ticks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_en  in  1  one-cycle timebase strobe; the timer advances only on this strobe.
- sensor  in  1  side-road vehicle present (synchronous, level).
- hw_led  out  3  highway lamps, {green, yellow, red}.
- sr_led  out  3  side-road lamps, {green, yellow, red}.
- phase  out  3  current state encoding, for debug.
- time_out  out  1  one-cycle pulse in the first cycle of each new phase.

Behaviour:
- States, in fixed order:
  - HW_GREEN(0) -> HW_YELLOW(1) -> RED_A(2) -> SR_GREEN(3) -> SR_YELLOW(4) -> RED_B(5) -> HW_GREEN.
  - Encodings 6 and 7 are illegal; they recover to HW_GREEN on the next clk and pulse time_out.
- Timer:
  - On entry to a phase, load (duration - 1).
  - On a cycle with tick_en=1 and timer != 0: decrement.
  - On a cycle with tick_en=1 and timer == 0: the phase expires.
  - Phase duration is therefore exactly D tick_en strobes.
- Request latch req:
  - Set on any cycle where sensor=1 in HW_GREEN, HW_YELLOW, RED_A or RED_B.
  - Cleared on the SR_GREEN entry edge. Sensor is ignored during SR_GREEN and SR_YELLOW.
- Exit from HW_GREEN:
  - Requires expiry AND (req OR sensor).
  - Without a request, HW_GREEN holds indefinitely with timer at 0.
  - The transition occurs on the first tick_en after a request arrives.
- All other phases exit unconditionally on expiry.
- Outputs, all registered:
  - hw_led = 100 in HW_GREEN, 010 in HW_YELLOW, 001 otherwise.
  - sr_led = 100 in SR_GREEN, 010 in SR_YELLOW, 001 otherwise.
  - The two heads are never simultaneously non-red.
  - The output update lands on the same clk edge as the state update; no extra latency.
- time_out: high for exactly one cycle, coincident with the first cycle of the new state.
- Reset values:
  - state = HW_GREEN, timer = HW_GREEN_MIN-1, req = 0.
  - hw_led = 100, sr_led = 001, phase = 0, time_out = 0.
- Reset mid-phase: immediate return to the reset values; a pending req is lost.
- Parameter rules: every duration must be ≥1 and ≤ 2^CNT_W. Check at elaboration; out-of-range values are a fatal error.

Optional Feature:
- Macro: JUNCTION_PED_REQ_EN.
- When defined:
  - Adds input ped_req (1 bit) and output ped_walk (1 bit, reset 0).
  - ped_req sets req under the same state rules as sensor.
  - ped_walk = 1 throughout SR_GREEN, 0 otherwise.
- When undefined: neither port exists and behaviour is as above.

Decomposition:
- Package junction_pkg holds:
  - State localparams.
  - LED encodings LED_GREEN=100, LED_YELLOW=010, LED_RED=001.
- One sub-module, phase_timer: CNT_W-bit loadable down-counter.
  - Inputs: load, load_val, tick_en.
  - Output: expired (= tick_en & count==0).
- FSM, request latch and output decode stay in junction_phase_scheduler.

Test Plan:
Common setup: HW_GREEN_MIN=3, YELLOW_T=2, ALL_RED_T=1, SR_GREEN_T=3, tick_en=1 every cycle.
1. Reset release, sensor=0 for 50 cycles -> state stays HW_GREEN, hw_led=100, sr_led=001, time_out never asserted.
2. One-cycle sensor pulse at cycle 1 -> HW_YELLOW entered at cycle 3; phases then last 2,1,3,2,1 cycles; back to HW_GREEN at cycle 12; exactly 6 time_out pulses.
3. Sensor held at 1 continuously -> continuous cycling with HW_GREEN exactly 3 cycles each lap; hw_led and sr_led never both non-red.
4. tick_en every 4th cycle, sensor pulse at cycle 1 -> HW_GREEN lasts 12 cycles (strobes at cycles 3, 7, 11; exits at 12); timer frozen between strobes.
5. rst_n asserted mid-SR_GREEN -> same cycle (asynchronous): sr_led=001, hw_led=100, phase=0, req=0; no time_out pulse.
6. With JUNCTION_PED_REQ_EN, ped_req pulse while sensor=0 -> same sequence as scenario 2; ped_walk=1 for exactly the 3 SR_GREEN cycles.
